// File: rtl/result_batch_reader.sv
// Captures CNN result words into a local buffer and returns them to the processor
// in packed batches of BATCH signed fields per rd_en strobe.
// Optional build macro: RESULT_SAT_EN (saturate instead of truncate on capture).
//
// state | meaning
// IDLE  | waiting for rd_en
// RD    | issuing BATCH synchronous buffer reads, one per cycle
// PACK  | last read data arrives; packed word driven on gpio_io_o
module result_batch_reader #(
  parameter int RES_IN_W  = 16,
  parameter int DATA_W    = 10,
  parameter int BATCH     = 3,
  parameter int DEPTH     = 48,
  parameter int EXPECT_M1 = 42,
  parameter int EXPECT_M0 = 36
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       cal_start,
  input  logic                       mode,
  input  logic                       rd_en,
  input  logic                       res_valid,
  input  logic signed [RES_IN_W-1:0] res_data,
  output logic [31:0]                gpio_io_o,
  output logic                       out_valid,
  output logic                       cal_done,
  output logic                       rd_busy,
  output logic                       err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int K_W    = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] EXP1_P  = PTR_W'(EXPECT_M1);
  localparam logic [PTR_W-1:0] EXP0_P  = PTR_W'(EXPECT_M0);
  localparam logic [PTR_W-1:0] BATCH_P = PTR_W'(BATCH);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(BATCH - 1);

  typedef enum logic [1:0] {IDLE, RD, PACK} state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                mode_q, mode_d;
  logic                cal_done_q, cal_done_d;
  logic                err_q, err_d;
  logic                toggle_q, toggle_d;
  logic                uf_q, uf_d;
  logic [31:0]         gpio_q, gpio_d;
  logic                out_valid_q, out_valid_d;
  logic                rd_vld_q, rd_vld_d;
  logic [K_W-1:0]      rd_idx_q, rd_idx_d;
  logic                rd_zero_q, rd_zero_d;
  logic [DATA_W-1:0]   fields_q [BATCH];
  logic [DATA_W-1:0]   fields_d [BATCH];

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   buf_rd_q;
  logic [DATA_W-1:0]   conv_data;
  logic                wr_en;
  logic                rd_issue;
  logic [PTR_W-1:0]    rd_sum;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_oob;
  logic [PTR_W-1:0]    nxt_sum;
  logic [PTR_W-1:0]    expect_cnt;
  logic [29:0]         packed_d;

`ifdef RESULT_SAT_EN
  localparam logic signed [RES_IN_W-1:0] SAT_MAX = RES_IN_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [RES_IN_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (res_data > SAT_MAX)      conv_data = SAT_MAX[DATA_W-1:0];
    else if (res_data < SAT_MIN) conv_data = SAT_MIN[DATA_W-1:0];
    else                         conv_data = res_data[DATA_W-1:0];
  end
`else
  logic unused_res_hi;
  assign conv_data     = res_data[DATA_W-1:0];
  assign unused_res_hi = ^res_data[RES_IN_W-1:DATA_W];
`endif

  assign wr_en      = res_valid && !cal_start && (wr_ptr_q < DEPTH_P);
  assign rd_issue   = (state_q == RD) && !cal_start;
  assign expect_cnt = mode_q ? EXP1_P : EXP0_P;

  // Read address and next batch pointer both wrap modulo DEPTH.
  always_comb begin
    rd_sum = {1'b0, rd_ptr_q} + PTR_W'(k_q);
    if (rd_sum >= DEPTH_P) rd_sum = rd_sum - DEPTH_P;
    rd_addr = rd_sum[ADDR_W-1:0];
    rd_oob  = (rd_sum >= wr_ptr_q);
    nxt_sum = {1'b0, rd_ptr_q} + BATCH_P;
    if (nxt_sum >= DEPTH_P) nxt_sum = nxt_sum - DEPTH_P;
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en)    mem_q[wr_ptr_q[ADDR_W-1:0]] <= conv_data;
    if (rd_issue) buf_rd_q <= mem_q[rd_addr];
  end

  // Read data lands one cycle after issue; it is folded into fields_d so
  // PACK can use the final field without an extra cycle.
  always_comb begin
    for (int i = 0; i < BATCH; i++) fields_d[i] = fields_q[i];
    if (rd_vld_q && !cal_start)
      fields_d[rd_idx_q] = rd_zero_q ? '0 : buf_rd_q;
    packed_d = '0;
    for (int i = 0; i < BATCH; i++) packed_d[i*DATA_W +: DATA_W] = fields_d[i];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mode_d      = mode_q;
    cal_done_d  = cal_done_q;
    err_d       = err_q;
    toggle_d    = toggle_q;
    uf_d        = uf_q;
    gpio_d      = gpio_q;
    out_valid_d = 1'b0;
    rd_vld_d    = 1'b0;
    rd_idx_d    = rd_idx_q;
    rd_zero_d   = 1'b0;

    if (cal_start) begin
      state_d    = IDLE;
      k_d        = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mode_d     = mode;
      cal_done_d = 1'b0;
      err_d      = 1'b0;
      toggle_d   = 1'b0;
      uf_d       = 1'b0;
      gpio_d     = '0;
    end else begin
      cal_done_d = (wr_ptr_q >= expect_cnt);
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (res_valid && (wr_ptr_q == DEPTH_P)) err_d = 1'b1;
      if (rd_en && (state_q != IDLE)) err_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (rd_en) begin
            state_d = RD;
            k_d     = '0;
            uf_d    = 1'b0;
          end
        end
        RD: begin
          rd_vld_d  = 1'b1;
          rd_idx_d  = k_q;
          rd_zero_d = rd_oob;
          if (rd_oob) uf_d = 1'b1;
          if (k_q == K_LAST) state_d = PACK;
          else               k_d = k_q + 1'b1;
        end
        PACK: begin
          toggle_d    = ~toggle_q;
          gpio_d      = {~toggle_q, uf_q, packed_d};
          out_valid_d = 1'b1;
          rd_ptr_d    = nxt_sum[ADDR_W-1:0];
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mode_q      <= 1'b1;
      cal_done_q  <= 1'b0;
      err_q       <= 1'b0;
      toggle_q    <= 1'b0;
      uf_q        <= 1'b0;
      gpio_q      <= '0;
      out_valid_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      rd_zero_q   <= 1'b0;
      for (int i = 0; i < BATCH; i++) fields_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mode_q      <= mode_d;
      cal_done_q  <= cal_done_d;
      err_q       <= err_d;
      toggle_q    <= toggle_d;
      uf_q        <= uf_d;
      gpio_q      <= gpio_d;
      out_valid_q <= out_valid_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      rd_zero_q   <= rd_zero_d;
      for (int i = 0; i < BATCH; i++) fields_q[i] <= fields_d[i];
    end
  end

  assign gpio_io_o = gpio_q;
  assign out_valid = out_valid_q;
  assign cal_done  = cal_done_q;
  assign rd_busy   = (state_q != IDLE);
  assign err       = err_q;

endmodule
